// File: rtl/core_pkg.sv
// core_pkg: opcode, sequencer state and PC-source encodings shared by the control path.
package core_pkg;
    typedef enum logic [3:0] {
        NOPE = 4'd0, LOADI = 4'd1, LOAD = 4'd2, STORE = 4'd3,
        INC = 4'd4, DEC = 4'd5, SNIB = 4'd6, SNIE = 4'd7,
        MOVE = 4'd8, BUN = 4'd9, HALT = 4'd10, SNIEV = 4'd11,
        SNIOD = 4'd12, RESET = 4'd13, ADD = 4'd14, SNIZ = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALTED = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_INC = 2'd0, PC_SKIP = 2'd1, PC_BRANCH = 2'd2
    } pc_src_e;

    function automatic logic is_skip(op_e op);
        return op inside {SNIB, SNIE, SNIEV, SNIOD, SNIZ};
    endfunction
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: request/ack handshake between the sequencer and the shared memory.
interface multicycle_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;
    modport master (output mem_req, mem_we, addr_sel, input mem_ack);
    modport slave  (input mem_req, mem_we, addr_sel, output mem_ack);
endinterface

// File: rtl/perf_counters.sv
// perf_counters: free-running active-cycle and retired-instruction counters, wrapping.
module perf_counters #(
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  retire,
    output logic [PERF_WIDTH-1:0] cycle_cnt,
    output logic [PERF_WIDTH-1:0] retired_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (active) cycle_cnt <= cycle_cnt + PERF_WIDTH'(1);
            if (retire) retired_cnt <= retired_cnt + PERF_WIDTH'(1);
        end
    end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM for the 16-opcode accumulator core.
// Define MULTICYCLE_SEQUENCER_PERF_EN to add the cycle_cnt/retired_cnt counters.
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int PERF_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    skip_cond,
    multicycle_sequencer_if.master  mem,
    output logic                    ir_load,
    output logic                    pc_en,
    output logic [1:0]              pc_src,
    output logic                    reg_we,
    output logic                    mem_to_reg,
    output logic                    immediate_en,
    output logic                    halted,
    output logic [2:0]              state_o
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]   cycle_cnt,
    output logic [PERF_WIDTH-1:0]   retired_cnt
`endif
);
    state_e state, state_n;
    op_e    op;

    // opcodes beyond the 16 defined ones behave as NOPE
    assign op = ((opcode >> 4) != '0) ? NOPE : op_e'(opcode[3:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_n;
    end

    always_comb begin
        state_n      = state;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_INC;
        reg_we       = 1'b0;
        mem_to_reg   = 1'b0;
        immediate_en = 1'b0;
        halted       = 1'b0;
        state_o      = state;
        case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) begin
                    ir_load = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                pc_en   = (op == NOPE);
                state_n = (op == HALT) ? HALTED : (op == NOPE) ? FETCH : EXEC;
            end
            EXEC: begin
                if (op inside {LOAD, STORE}) begin
                    state_n = MEM;
                end else if (op == BUN) begin
                    pc_en   = 1'b1;
                    pc_src  = PC_BRANCH;
                    state_n = FETCH;
                end else if (is_skip(op)) begin
                    pc_en   = 1'b1;
                    pc_src  = skip_cond ? PC_SKIP : PC_INC;
                    state_n = FETCH;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (op == STORE);
                if (mem.mem_ack) begin
                    pc_en   = (op == STORE);
                    state_n = (op == STORE) ? FETCH : WB;
                end
            end
            WB: begin
                reg_we       = 1'b1;
                mem_to_reg   = op inside {LOAD, LOADI};
                immediate_en = (op == LOADI);
                pc_en        = 1'b1;
                state_n      = FETCH;
            end
            HALTED: halted = 1'b1;
            default: state_n = FETCH;
        endcase
        // reset silences every output in the same cycle, abandoning any open request
        if (rst) begin
            state_n      = FETCH;
            mem.mem_req  = 1'b0;
            mem.mem_we   = 1'b0;
            mem.addr_sel = 1'b0;
            ir_load      = 1'b0;
            pc_en        = 1'b0;
            pc_src       = PC_INC;
            reg_we       = 1'b0;
            mem_to_reg   = 1'b0;
            immediate_en = 1'b0;
            halted       = 1'b0;
            state_o      = FETCH;
        end
    end

`ifdef MULTICYCLE_SEQUENCER_PERF_EN
    perf_counters #(.PERF_WIDTH(PERF_WIDTH)) u_perf (
        .clk        (clk),
        .rst        (rst),
        .active     (state != HALTED),
        .retire     (pc_en),
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt)
    );
`else
    localparam int unused_perf_width = PERF_WIDTH;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and random instruction streams checked against a phase-list model.
module tb_multicycle_sequencer;
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALTED = 5;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] opcode;
    logic skip_cond;
    logic ir_load, pc_en, reg_we, mem_to_reg, immediate_en, halted;
    logic [1:0] pc_src;
    logic [2:0] state_o;
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
    int exp_cycles = 0, exp_retired = 0;
`endif
    int n_chk = 0, n_fail = 0;

    multicycle_sequencer_if mif ();

    always #5 clk = ~clk;

    multicycle_sequencer #(.OPCODE_WIDTH(4), .PERF_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .skip_cond   (skip_cond),
        .mem         (mif.master),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .mem_to_reg  (mem_to_reg),
        .immediate_en(immediate_en),
        .halted      (halted),
        .state_o     (state_o)
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    typedef struct {int ph; logic ack;} step_t;

    // {state[13:11], req, we, addr_sel, ir_load, pc_en[6], pc_src[5:4], reg_we, mem_to_reg, imm, halted}
    function automatic logic [13:0] expect_out(int ph, logic [3:0] op, logic ack, logic sk);
        logic req = 0, we = 0, as = 0, irl = 0, pce = 0, rwe = 0, m2r = 0, imm = 0, hlt = 0;
        logic [1:0] src = 0;
        case (ph)
            P_FETCH: begin req = 1; irl = ack; end
            P_DECODE: pce = (op == 0);
            P_EXEC: begin
                if (op inside {6, 7, 11, 12, 15}) begin pce = 1; src = sk ? 2'd1 : 2'd0; end
                if (op == 9) begin pce = 1; src = 2'd2; end
            end
            P_MEM: begin req = 1; as = 1; we = (op == 3); pce = ack && (op == 3); end
            P_WB: begin rwe = 1; m2r = (op == 1 || op == 2); imm = (op == 1); pce = 1; end
            default: hlt = 1;
        endcase
        return {3'(ph), req, we, as, irl, pce, src, rwe, m2r, imm, hlt};
    endfunction

    task automatic cycle(logic r, int ph, logic [3:0] op, logic ack);
        logic [13:0] exp, got;
        rst = r;
        opcode = (ph == P_FETCH) ? 4'($urandom) : op;
        skip_cond = 1'($urandom);
        mif.mem_ack = ack;
        #4;
        exp = r ? 14'd0 : expect_out(ph, op, ack, skip_cond);
        got = {state_o, mif.mem_req, mif.mem_we, mif.addr_sel, ir_load, pc_en, pc_src,
               reg_we, mem_to_reg, immediate_en, halted};
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL outputs ph=%0d op=%0d rst=%0b ack=%0b got=%h exp=%h", ph, op, r, ack, got, exp);
        end
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
        n_chk++;
        assert (cycle_cnt === 32'(exp_cycles) && retired_cnt === 32'(exp_retired)) else begin
            n_fail++;
            $error("FAIL perf got=%0d/%0d exp=%0d/%0d", cycle_cnt, retired_cnt, exp_cycles, exp_retired);
        end
        if (r) begin exp_cycles = 0; exp_retired = 0; end
        else begin
            if (ph != P_HALTED) exp_cycles++;
            if (exp[6]) exp_retired++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // build the instruction's phase list from the latency rules, then play it
    task automatic run_instr(logic [3:0] op, int wf, int wm, int rst_at);
        step_t q[$];
        for (int i = 0; i < wf; i++) q.push_back('{P_FETCH, 1'b0});
        q.push_back('{P_FETCH, 1'b1});
        q.push_back('{P_DECODE, 1'($urandom)});
        if (op == 10) begin
            for (int i = 0; i < 3; i++) q.push_back('{P_HALTED, 1'($urandom)});
        end else if (op != 0) begin
            q.push_back('{P_EXEC, 1'($urandom)});
            if (op == 2 || op == 3) begin
                for (int i = 0; i < wm; i++) q.push_back('{P_MEM, 1'b0});
                q.push_back('{P_MEM, 1'b1});
            end
            if (!(op inside {3, 6, 7, 9, 11, 12, 15})) q.push_back('{P_WB, 1'($urandom)});
        end
        foreach (q[i]) begin
            if (i == rst_at) begin
                cycle(1'b1, P_FETCH, op, 1'b0);
                return;
            end
            cycle(1'b0, q[i].ph, op, q[i].ack);
        end
        if (op == 10) cycle(1'b1, P_FETCH, op, 1'b0);
    endtask

    initial begin
        mif.mem_ack = 1'b0;
        cycle(1'b1, P_FETCH, 4'd0, 1'b0);
        cycle(1'b1, P_FETCH, 4'd0, 1'b0);
        run_instr(4'd4, 0, 0, -1);
        run_instr(4'd14, 0, 0, -1);
        run_instr(4'd0, 0, 0, -1);
        run_instr(4'd10, 0, 0, -1);
        run_instr(4'd2, 0, 3, -1);
        run_instr(4'd3, 1, 2, -1);
        run_instr(4'd1, 2, 0, -1);
        for (int i = 0; i < 4; i++) run_instr(4'd15, 0, 0, -1);
        run_instr(4'd9, 0, 0, -1);
        run_instr(4'd2, 0, 5, 5);
        run_instr(4'd3, 1, 4, 6);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        cycle(1'b1, P_FETCH, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) run_instr(4'd4, 0, 0, -1);
`ifdef MULTICYCLE_SEQUENCER_PERF_EN
        n_chk++;
        assert (exp_cycles == 40 && exp_retired == 10 && cycle_cnt === 32'd40 && retired_cnt === 32'd10) else begin
            n_fail++;
            $error("FAIL perf_inc10 got=%0d/%0d exp=40/10", cycle_cnt, retired_cnt);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
